// File: rtl/dfe_cfg_pkg.sv
// Shared DFE configuration types: region select encoding, sequencer states,
// and the region-to-slave-select helper used by the APB config sequencer.
package dfe_cfg_pkg;

    localparam int NUM_DENUM   = 5;
    localparam int NUM_REGIONS = 4;

    typedef enum logic [1:0] {
        FRAC_DECI,
        IIR,
        CTRL,
        CIC
    } region_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        DONE
    } seq_state_e;

    function automatic logic [NUM_REGIONS-1:0] region_sel(input region_e r);
        return NUM_REGIONS'(1) << r;
    endfunction

endpackage

// File: rtl/apb_cfg_sequencer.sv
// APB configuration sequencer: turns one command into a burst of APB writes
// fed from a coefficient stream, or into a single APB read.
// Ports: cmd_* command handshake, s_* coefficient stream, M* APB master,
// rd_valid/rd_data read return, busy/done/err/words_done status.
module apb_cfg_sequencer
    import dfe_cfg_pkg::*;
#(
    parameter int COEFF_WIDTH = 20,
    parameter int PDATA_WIDTH = 32,
    parameter int COMP        = 4,
    parameter int N_TAP       = 146,
    parameter int ADDR_WIDTH  = $clog2(N_TAP + 2*NUM_DENUM + 9),
    parameter int XFER_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [1:0]             cmd_sel,
    input  logic [ADDR_WIDTH-1:0]  cmd_base,
    input  logic [ADDR_WIDTH:0]    cmd_len,
    input  logic                   cmd_abort,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [COEFF_WIDTH-1:0] s_data,
    output logic                   MTRANS,
    output logic                   MWRITE,
    output logic [COMP-1:0]        MSELx,
    output logic [ADDR_WIDTH-1:0]  MADDR,
    output logic [COEFF_WIDTH-1:0] MWDATA,
    input  logic [PDATA_WIDTH-1:0] MRDATA,
    output logic                   rd_valid,
    output logic [PDATA_WIDTH-1:0] rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ADDR_WIDTH:0]    words_done
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam int CW = $clog2(XFER_CYCLES + 1);
    localparam logic [ADDR_WIDTH+1:0] SPACE = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;

    seq_state_e             state;
    logic                   wr_q;
    region_e                sel_q;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [LW-1:0]          len_q;
    logic [CW-1:0]          cnt_q;
    logic                   abort_pend;

    logic [LW-1:0]          len_eff;
    logic [ADDR_WIDTH+1:0]  end_addr;
    logic                   bad_cmd;
    logic                   abort_now;
    logic [LW-1:0]          wd_nxt;

    always_comb begin
        len_eff   = cmd_write ? cmd_len : LW'(1);
        end_addr  = {2'b00, cmd_base} + {1'b0, len_eff};
        bad_cmd   = (len_eff == '0) || (end_addr > SPACE);
        abort_now = abort_pend | cmd_abort;
        wd_nxt    = words_done + LW'(1);
    end

    // words_done doubles as the burst index: it counts completed writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            sel_q      <= FRAC_DECI;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            abort_pend <= 1'b0;
            cmd_ready  <= 1'b0;
            s_ready    <= 1'b0;
            MTRANS     <= 1'b0;
            MWRITE     <= 1'b0;
            MSELx      <= '0;
            MADDR      <= '0;
            MWDATA     <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            words_done <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            MTRANS   <= 1'b0;
            if (state != IDLE && cmd_abort)
                abort_pend <= 1'b1;
            case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    cmd_ready  <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        wr_q       <= cmd_write;
                        sel_q      <= region_e'(cmd_sel);
                        base_q     <= cmd_base;
                        len_q      <= len_eff;
                        words_done <= '0;
                        err        <= 1'b0;
                        if (bad_cmd) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            if (cmd_write) begin
                                state   <= FETCH;
                                s_ready <= 1'b1;
                            end else begin
                                state  <= ISSUE;
                                MTRANS <= 1'b1;
                                MWRITE <= 1'b0;
                                MSELx  <= COMP'(region_sel(region_e'(cmd_sel)));
                                MADDR  <= cmd_base;
                            end
                        end
                    end
                end
                FETCH: begin
                    // s_ready already dropped when the abort was seen,
                    // so no word is taken on the way out.
                    if (abort_pend) begin
                        state   <= DONE;
                        s_ready <= 1'b0;
                        done    <= 1'b1;
                        MSELx   <= '0;
                        MWRITE  <= 1'b0;
                    end else if (s_valid && s_ready) begin
                        state   <= ISSUE;
                        s_ready <= 1'b0;
                        MWDATA  <= s_data;
                        MTRANS  <= 1'b1;
                        MWRITE  <= 1'b1;
                        MSELx   <= COMP'(region_sel(sel_q));
                        MADDR   <= base_q + words_done[ADDR_WIDTH-1:0];
                    end else if (cmd_abort) begin
                        s_ready <= 1'b0;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt_q <= CW'(XFER_CYCLES - 1);
                end
                WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        if (wr_q) begin
                            words_done <= wd_nxt;
                            if (wd_nxt == len_q || abort_now) begin
                                state  <= DONE;
                                done   <= 1'b1;
                                MSELx  <= '0;
                                MWRITE <= 1'b0;
                            end else begin
                                state   <= FETCH;
                                s_ready <= 1'b1;
                            end
                        end else begin
                            rd_data  <= MRDATA;
                            rd_valid <= 1'b1;
                            state    <= DONE;
                            done     <= 1'b1;
                            MSELx    <= '0;
                            MWRITE   <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_cfg_sequencer.md
Name: apb_cfg_sequencer

Overview:
- Command-driven master that programs the DFE configuration space through the APB bridge master port (MTRANS/MWRITE/MSELx/MADDR/MWDATA/MRDATA).
- Expands one command into a burst of single APB writes from a coefficient stream, or performs a single APB read.
- Covers FRAC_DECI taps, IIR coefficients, CTRL and CIC regions.
- Sits between the host/config front end and the APB top.

Parameters:
- COEFF_WIDTH, 20, width of one coefficient/data word on MWDATA and the stream.
- PDATA_WIDTH, 32, width of MRDATA and rd_data.
- COMP, 4, number of APB slave selects (one-hot MSELx).
- N_TAP, 146, FRAC_DECI tap count.
- ADDR_WIDTH, $clog2(N_TAP+2*5+9) = 8, APB address width.
- XFER_CYCLES, 3, fixed cycles from MTRANS pulse to transfer complete; minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = single read.
- cmd_sel  in  2  region: 0 FRAC_DECI, 1 IIR, 2 CTRL, 3 CIC.
- cmd_base  in  ADDR_WIDTH  first address.
- cmd_len  in  ADDR_WIDTH+1  word count; forced to 1 for reads.
- cmd_abort  in  1  stop the burst after the current transfer.
- s_valid  in  1  coefficient word valid.
- s_ready  out  1  coefficient word consumed.
- s_data  in  COEFF_WIDTH  signed coefficient.
- MTRANS  out  1  APB transfer request pulse.
- MWRITE  out  1  APB direction.
- MSELx  out  COMP  one-hot slave select.
- MADDR  out  ADDR_WIDTH  APB address.
- MWDATA  out  COEFF_WIDTH  APB write data.
- MRDATA  in  PDATA_WIDTH  APB read data.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- rd_data  out  PDATA_WIDTH  captured read data.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at command end.
- err  out  1  sticky error; cleared by the next accepted command.
- words_done  out  ADDR_WIDTH+1  writes completed in the current or last command.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE.
- State IDLE:
  - cmd_ready=1.
  - On accept: latch the command, clear words_done and err.
  - Error check: if cmd_len==0 or cmd_base+cmd_len > 2^ADDR_WIDTH, set err, pulse done next cycle, return to IDLE. No APB activity.
  - Otherwise go to FETCH (write) or ISSUE (read).
- State FETCH:
  - s_ready=1.
  - On s_valid: register s_data into MWDATA, go to ISSUE.
  - If abort is pending: go to DONE without consuming a word.
- State ISSUE, exactly one cycle:
  - MTRANS=1; MWRITE, MSELx=1<<sel and MADDR=base+index are all driven.
  - Go to WAIT and load the counter with XFER_CYCLES-1.
- State WAIT:
  - MSELx, MADDR, MWDATA and MWRITE held stable; MTRANS=0.
  - Counter decrements; at 0 the transfer is complete.
  - Write complete: words_done++ and index++. If index==len or abort is pending, go to DONE; else go to FETCH.
  - Read complete: capture MRDATA into rd_data, pulse rd_valid, go to DONE.
- State DONE, one cycle:
  - done=1; MSELx and MWRITE go to 0.
  - Go to IDLE.
- Abort: cmd_abort is sampled in any non-IDLE state and sets abort_pend, which is cleared in IDLE. A transfer in flight always completes; APB is never cut mid-transfer.
- Minimum throughput: XFER_CYCLES+1 cycles per word with s_valid held high. Default 4 cycles, i.e. FETCH + ISSUE + 2 WAIT.
- s_ready is asserted only in FETCH. Stream words are never dropped or duplicated.
- Address arithmetic is ADDR_WIDTH wide; wrap cannot occur because of the accept-time check.
- cmd_valid while busy is ignored (cmd_ready=0).
- Reset mid-burst: immediate return to IDLE; the partial burst is not resumed.

Decomposition:
- Shared package dfe_cfg_pkg holds:
  - enum region_e {FRAC_DECI, IIR, CTRL, CIC} and the constant NUM_DENUM=5.
  - Region-to-MSELx one-hot function.
  - State enum seq_state_e {IDLE, FETCH, ISSUE, WAIT, DONE}.
- No sub-module; the XFER_CYCLES down-counter stays inline.

Test Plan:
- Write burst, sel=0, base=0, len=146, stream always valid:
  - 146 MTRANS pulses, spaced 4 cycles apart, with MADDR 0..145 and MSELx=0001.
  - done pulse follows; words_done=146; err=0.
- IIR write, base=0, len=10, with s_valid toggling every other cycle:
  - MADDR 0..9 and MSELx=0010.
  - MWDATA equals the stream order (e.g. 0x7FFFF, 0x80000, ...).
  - No MTRANS is issued while FETCH is stalled.
- Read, sel=2, addr=3, MRDATA=0x0000_0015 at completion:
  - Exactly one MTRANS with MWRITE=0.
  - rd_valid pulses 3 cycles after MTRANS with rd_data=0x15, then done.
- Error commands, len=0, and base=250 with len=10:
  - err=1 and done pulse, with zero MTRANS pulses.
  - The next valid command clears err.
- Abort asserted during the WAIT of word 5 of a 20-word burst:
  - Word 5 completes; words_done=5; done pulses.
  - s_ready stays low afterward.
- rst_n low during the WAIT of word 3:
  - All outputs return to 0 asynchronously.
  - After release, a new command starts cleanly at its base address.
